// File: rtl/bht_btb_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: IF lookup, EX resolution and mispredict flag.
// Valid/ready: no handshake; EX training is qualified by upd_en & is_br_EX, and IF lookups are unconditional.
interface bht_btb_predictor_if;
  logic [31:0] PC_IF;
  logic        find;
  logic        jmp;
  logic [31:0] NPC_Pred;
  logic        upd_en;
  logic        is_br_EX;
  logic        br_EX;
  logic [31:0] PC_EX;
  logic [31:0] br_target;
  logic        find_EX;
  logic        jmp_EX;
  logic [31:0] NPC_Pred_EX;
  logic        fail;

  modport master (
    output PC_IF, upd_en, is_br_EX, br_EX, PC_EX, br_target, find_EX, jmp_EX, NPC_Pred_EX,
    input  find, jmp, NPC_Pred, fail
  );

  modport slave (
    input  PC_IF, upd_en, is_br_EX, br_EX, PC_EX, br_target, find_EX, jmp_EX, NPC_Pred_EX,
    output find, jmp, NPC_Pred, fail
  );
endinterface

// File: rtl/bht_btb_predictor.sv
// Direct-mapped BTB with saturating-counter BHT: zero-latency IF prediction, EX-stage training.
// Optional statistics counters (br_cnt, mispred_cnt) are built when BHT_STATS_EN is defined.
module bht_btb_predictor #(
  parameter int ENTRY_BITS  = 6,
  parameter int CNT_WIDTH   = 2,
  parameter int STATS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  bht_btb_predictor_if.slave     bus
`ifdef BHT_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] br_cnt,
  output logic [STATS_WIDTH-1:0] mispred_cnt
`endif
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 32 - ENTRY_BITS - 2;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT  = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ALLOC = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [ENTRIES];
  logic [TAG_W-1:0]     tag_d [ENTRIES];
  logic [31:0]          tgt_q [ENTRIES];
  logic [31:0]          tgt_d [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_q [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_d [ENTRIES];

  logic [ENTRY_BITS-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0]      tag_if, tag_ex;
  logic                  hit_ex, train;
  logic [CNT_WIDTH-1:0]  cnt_ex, cnt_inc, cnt_dec;

  assign idx_if = bus.PC_IF[ENTRY_BITS+1:2];
  assign tag_if = bus.PC_IF[31:ENTRY_BITS+2];
  assign idx_ex = bus.PC_EX[ENTRY_BITS+1:2];
  assign tag_ex = bus.PC_EX[31:ENTRY_BITS+2];

  // Lookup reads only the registered table, so a same-index update is seen next cycle.
  always_comb begin
    bus.find     = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    bus.jmp      = bus.find && cnt_q[idx_if][CNT_WIDTH-1];
    bus.NPC_Pred = bus.jmp ? tgt_q[idx_if] : (bus.PC_IF + 32'd4);
  end

  assign train    = bus.upd_en && bus.is_br_EX;
  assign bus.fail = train && ((bus.br_EX != bus.jmp_EX) ||
                              (bus.br_EX && bus.jmp_EX && (bus.NPC_Pred_EX != bus.br_target)));

  assign hit_ex  = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
  assign cnt_ex  = cnt_q[idx_ex];
  assign cnt_inc = (&cnt_ex) ? cnt_ex : (cnt_ex + CNT_ONE);
  assign cnt_dec = (cnt_ex == '0) ? cnt_ex : (cnt_ex - CNT_ONE);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (train) begin
      if (hit_ex) begin
        if (bus.br_EX) begin
          cnt_d[idx_ex] = cnt_inc;
          tgt_d[idx_ex] = bus.br_target;
        end else begin
          cnt_d[idx_ex] = cnt_dec;
        end
      end else if (bus.br_EX) begin
        // Taken miss evicts whatever aliases this index; not-taken misses are not worth a slot.
        valid_d[idx_ex] = 1'b1;
        tag_d[idx_ex]   = tag_ex;
        tgt_d[idx_ex]   = bus.br_target;
        cnt_d[idx_ex]   = CNT_ALLOC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_INIT;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [2:0] unused_bits;
  assign unused_bits = {bus.find_EX, bus.PC_EX[1:0]};

`ifdef BHT_STATS_EN
  logic [STATS_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [STATS_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (train && !(&br_cnt_q))
      br_cnt_d = br_cnt_q + STATS_WIDTH'(1);
    if (bus.fail && !(&mispred_cnt_q))
      mispred_cnt_d = mispred_cnt_q + STATS_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  logic [STATS_WIDTH-1:0] unused_stats;
  assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed bench for bht_btb_predictor (ENTRY_BITS=6, CNT_WIDTH=2); stats checks when BHT_STATS_EN is defined.
module tb_bht_btb_predictor;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  bht_btb_predictor_if bus ();

`ifdef BHT_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
`endif

  bht_btb_predictor #(
    .ENTRY_BITS (6),
    .CNT_WIDTH  (2),
    .STATS_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef BHT_STATS_EN
    ,
    .br_cnt     (br_cnt),
    .mispred_cnt(mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one EX-stage slot at the falling edge; the update lands on the next rising edge.
  task automatic ex_step(input logic u, input logic ib, input logic b, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic jx, input logic [31:0] nx,
                         input logic [31:0] pc_if);
    @(negedge clk);
    bus.upd_en      = u;
    bus.is_br_EX    = ib;
    bus.br_EX       = b;
    bus.PC_EX       = pc;
    bus.br_target   = tgt;
    bus.find_EX     = jx;
    bus.jmp_EX      = jx;
    bus.NPC_Pred_EX = nx;
    bus.PC_IF       = pc_if;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.upd_en   = 1'b0;
    bus.is_br_EX = 1'b0;
    bus.br_EX    = 1'b0;
    bus.jmp_EX   = 1'b0;
    bus.find_EX  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.PC_IF = pc;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.PC_IF = 32'h100; bus.upd_en = 1'b0; bus.is_br_EX = 1'b0; bus.br_EX = 1'b0;
    bus.PC_EX = '0; bus.br_target = '0; bus.find_EX = 1'b0; bus.jmp_EX = 1'b0; bus.NPC_Pred_EX = '0;
    #1;
    chk("rst_find", bus.find, 0);
    chk("rst_jmp", bus.jmp, 0);
    chk("rst_npc", bus.NPC_Pred, 32'h104);
    chk("rst_fail", bus.fail, 0);
`ifdef BHT_STATS_EN
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_mis_cnt", mispred_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    look(32'h100);
    chk("cold_find", bus.find, 0);
    chk("cold_jmp", bus.jmp, 0);
    chk("cold_npc", bus.NPC_Pred, 32'h104);

    // First taken branch allocates at counter=2.
    ex_step(1, 1, 1, 32'h100, 32'h80, 0, 32'h104, 32'h100);
    chk("alloc_fail", bus.fail, 1);
    chk("rdw_find", bus.find, 0);
    idle(); look(32'h100);
    chk("alloc_find", bus.find, 1);
    chk("alloc_jmp", bus.jmp, 1);
    chk("alloc_npc", bus.NPC_Pred, 32'h80);

    // Hysteresis: 2 -> 1 -> 0 -> 0 -> 1 -> 2.
    ex_step(1, 1, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
    chk("nt1_fail", bus.fail, 1);
    idle(); look(32'h100);
    chk("nt1_find", bus.find, 1);
    chk("nt1_jmp", bus.jmp, 0);
    chk("nt1_npc", bus.NPC_Pred, 32'h104);
    ex_step(1, 1, 0, 32'h100, 32'h80, 0, 32'h104, 32'h100);
    chk("nt2_fail", bus.fail, 0);
    idle(); look(32'h100);
    chk("nt2_jmp", bus.jmp, 0);
    ex_step(1, 1, 0, 32'h100, 32'h80, 0, 32'h104, 32'h100);
    chk("nt3_fail", bus.fail, 0);
    idle(); look(32'h100);
    chk("nt3_jmp", bus.jmp, 0);
    ex_step(1, 1, 1, 32'h100, 32'h80, 0, 32'h104, 32'h100);
    chk("t1_fail", bus.fail, 1);
    idle(); look(32'h100);
    chk("t1_jmp", bus.jmp, 0);
    chk("t1_npc", bus.NPC_Pred, 32'h104);
    ex_step(1, 1, 1, 32'h100, 32'h80, 0, 32'h104, 32'h100);
    chk("t2_fail", bus.fail, 1);
    idle(); look(32'h100);
    chk("t2_jmp", bus.jmp, 1);
    chk("t2_npc", bus.NPC_Pred, 32'h80);

    // Predicted taken but wrong target.
    ex_step(1, 1, 1, 32'h100, 32'h90, 1, 32'h80, 32'h100);
    chk("tmis_fail", bus.fail, 1);
    idle(); look(32'h100);
    chk("tmis_npc", bus.NPC_Pred, 32'h90);
    ex_step(1, 1, 1, 32'h100, 32'h90, 1, 32'h90, 32'h100);
    chk("tok_fail", bus.fail, 0);

    // Gated and non-branch slots leave the tables alone.
    ex_step(0, 1, 1, 32'h100, 32'h44, 0, 32'h104, 32'h100);
    chk("gate_fail", bus.fail, 0);
    idle(); look(32'h100);
    chk("gate_npc", bus.NPC_Pred, 32'h90);
    ex_step(1, 0, 1, 32'h300, 32'h50, 0, 32'h304, 32'h300);
    chk("nonbr_fail", bus.fail, 0);
    idle(); look(32'h300);
    chk("nonbr_find", bus.find, 0);
    ex_step(1, 1, 0, 32'h400, 32'h60, 0, 32'h404, 32'h400);
    chk("missnt_fail", bus.fail, 0);
    idle(); look(32'h400);
    chk("missnt_find", bus.find, 0);
    look(32'h100);
    chk("missnt_keep", bus.NPC_Pred, 32'h90);

    // Alias at index 0 with tag 2 replaces the 0x100 entry.
    ex_step(1, 1, 1, 32'h200, 32'h40, 0, 32'h204, 32'h200);
    chk("alias_fail", bus.fail, 1);
    idle(); look(32'h100);
    chk("alias_old_find", bus.find, 0);
    chk("alias_old_npc", bus.NPC_Pred, 32'h104);
    look(32'h200);
    chk("alias_new_find", bus.find, 1);
    chk("alias_new_npc", bus.NPC_Pred, 32'h40);

    ex_step(1, 1, 1, 32'h104, 32'h1000, 0, 32'h108, 32'h104);
    idle(); look(32'h104);
    chk("idx1_npc", bus.NPC_Pred, 32'h1000);
    look(32'h200);
    chk("idx0_keep_npc", bus.NPC_Pred, 32'h40);
    ex_step(1, 1, 0, 32'h200, 32'h40, 1, 32'h40, 32'h200);
    chk("alias_nt_fail", bus.fail, 1);
    idle(); look(32'h200);
    chk("alias_nt_find", bus.find, 1);
    chk("alias_nt_jmp", bus.jmp, 0);

    // Reset mid-update: nothing from the in-flight update survives.
    ex_step(1, 1, 1, 32'h104, 32'h2000, 1, 32'h1000, 32'h104);
    chk("midrst_fail_pre", bus.fail, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_find", bus.find, 0);
    chk("midrst_npc", bus.NPC_Pred, 32'h108);
    chk("midrst_fail", bus.fail, 1);
    idle();
    rst = 1'b0;
    look(32'h104);
    chk("postrst_find104", bus.find, 0);
    look(32'h200);
    chk("postrst_find200", bus.find, 0);

    // Three trains, one mispredict.
    ex_step(1, 1, 1, 32'h100, 32'h80, 0, 32'h104, 32'h100);
    chk("st1_fail", bus.fail, 1);
    ex_step(1, 1, 1, 32'h100, 32'h80, 1, 32'h80, 32'h100);
    chk("st2_fail", bus.fail, 0);
    ex_step(1, 1, 1, 32'h100, 32'h80, 1, 32'h80, 32'h100);
    chk("st3_fail", bus.fail, 0);
    idle(); look(32'h100);
    chk("st_jmp", bus.jmp, 1);
    chk("st_npc", bus.NPC_Pred, 32'h80);
`ifdef BHT_STATS_EN
    chk("st_br_cnt", br_cnt, 3);
    chk("st_mis_cnt", mispred_cnt, 1);
`endif
    #1 rst = 1'b1;
    #1;
    chk("st_rst_find", bus.find, 0);
`ifdef BHT_STATS_EN
    chk("st_rst_br_cnt", br_cnt, 0);
    chk("st_rst_mis_cnt", mispred_cnt, 0);
`endif
    idle();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bht_btb_predictor.md
# bht_btb_predictor

Parametrised direct-mapped branch target buffer with an N-bit saturating-counter branch history table, for the RV32I pipeline. It replaces the fixed single-bit BTB. The IF stage gets a zero-latency prediction (hit, direction, next PC). The EX stage reports resolved conditional branches; this block trains the tables and flags mispredictions to the NPC generator and hazard unit.

## Interface
Parameters:
- `ENTRY_BITS`, 6, log2 of table entries; index = PC[ENTRY_BITS+1:2].
- `CNT_WIDTH`, 2, saturating counter width (>=1); predicts taken when MSB = 1.
- `STATS_WIDTH`, 32, width of statistics counters (used only with the macro below).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `PC_IF`  in  32  fetch PC.
- `find`  out  1  IF lookup hit (valid entry with matching tag).
- `jmp`  out  1  predicted taken (`find` & counter MSB).
- `NPC_Pred`  out  32  predicted next PC: stored target if `jmp`, else PC_IF+4.
- `upd_en`  in  1  EX stage holds a live instruction (not bubbled, not flushed).
- `is_br_EX`  in  1  EX instruction is a conditional branch.
- `br_EX`  in  1  branch resolved taken.
- `PC_EX`  in  32  address of EX instruction.
- `br_target`  in  32  resolved branch target.
- `find_EX`, `jmp_EX`  in  1 each  IF prediction carried down the pipe.
- `NPC_Pred_EX`  in  32  predicted next PC carried down the pipe.
- `fail`  out  1  misprediction, combinational.
- `br_cnt`  out  STATS_WIDTH  resolved branches (macro only).
- `mispred_cnt`  out  STATS_WIDTH  mispredictions (macro only).

## Operation
- Tag = PC[31:ENTRY_BITS+2]. Each entry holds: valid, tag, 32-bit target, CNT_WIDTH counter.
- Lookup is purely combinational on `PC_IF`. On a miss: find=0, jmp=0, NPC_Pred=PC_IF+4.
- `train` = upd_en & is_br_EX.
- `fail` = train & ((br_EX != jmp_EX) | (br_EX & jmp_EX & NPC_Pred_EX != br_target)). It is 0 whenever train=0.
- Update on the clock edge when train=1. Index and tag come from `PC_EX`; hit is re-evaluated against the current table.
  - On a hit: the counter saturating-increments if br_EX, else saturating-decrements. If br_EX, target <= br_target.
  - On a miss with br_EX=1: allocate (replacing any aliasing entry). Set valid=1, tag, target=br_target, counter=2^(CNT_WIDTH-1) (weakly taken).
  - On a miss with br_EX=0: no change.
- Non-branches never allocate, and never modify the tables.

## Timing
- Prediction latency: 0 cycles (same cycle as PC_IF). Fail: 0 cycles (same cycle as EX inputs).
- Training is visible to lookups from the cycle after the update edge.
- Read-during-write at the same index: the lookup returns pre-update contents.
- Reset (asynchronous, any cycle, including mid-update) has these values, and no partial update survives:
  - all valid=0;
  - counters = 2^(CNT_WIDTH-1)-1 (weakly not-taken);
  - targets 0;
  - stats 0.
- Outputs during reset: find=0, jmp=0, NPC_Pred=PC_IF+4, fail follows its combinational inputs.
- With CNT_WIDTH=1, the counter is set on taken and cleared on not-taken. Allocation sets it to 1.

## Configuration
- `BHT_STATS_EN`: when defined, add `br_cnt` and `mispred_cnt`.
  - br_cnt increments on each train; mispred_cnt increments on each train with fail=1.
  - Both saturate at all-ones and clear on rst.
- When undefined, the ports are absent and no counter logic exists. Prediction behaviour is identical either way.

## Test plan
Defaults: ENTRY_BITS=6, CNT_WIDTH=2.
- Cold lookup: release rst, PC_IF=0x100 -> find=0, jmp=0, NPC_Pred=0x104.
- First taken branch allocates:
  - stimulus: upd_en=1, is_br_EX=1, br_EX=1, PC_EX=0x100, br_target=0x80, find_EX=0, jmp_EX=0;
  - same cycle: fail=1;
  - next cycle, PC_IF=0x100: find=1, jmp=1, NPC_Pred=0x80.
- Counter hysteresis:
  - from counter=2, three not-taken updates at 0x100 -> counter 1, 0, 0; jmp=0 after the first; NPC_Pred=0x104;
  - then two taken updates -> 1, 2; jmp=1 only after the second.
- Alias replacement: taken branch at PC_EX=0x200 (index 0, tag 0x000002), target 0x40 -> lookup 0x100 gives find=0; lookup 0x200 gives NPC_Pred=0x40.
- Gating and target mismatch:
  - upd_en=0 with is_br_EX=1 and br_EX=1 -> fail=0, tables unchanged;
  - jmp_EX=1, NPC_Pred_EX=0x80, br_EX=1, br_target=0x90 -> fail=1, target updated to 0x90.
- With BHT_STATS_EN: three trains with one misprediction -> br_cnt=3, mispred_cnt=1.
  - Then assert rst mid-cycle -> all stats 0 immediately, lookup 0x100 gives find=0.
